// File: rtl/conv_pkg.sv
// Shared constants for the OFM writeback slice: lane count, fixed-point defaults,
// FSM state encoding and the int8 saturation limits used by the requantizer.
package conv_pkg;

    localparam int LANES        = 16;
    localparam int Q_IN_DEFAULT = 5;
    localparam int Q_W_DEFAULT  = 8;

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } st_t;

endpackage

// File: rtl/ofm_writeback_if.sv
// Accumulator stream (valid/ready) plus the output BRAM write port of ofm_writeback.
// slave = the writeback block, master = the producer/memory side.
interface ofm_writeback_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int ACC_WIDTH  = 16
);

    logic                        acc_valid;
    logic signed [ACC_WIDTH-1:0] acc_data;
    logic                        acc_ready;

    logic                        ofm_we;
    logic [ADDR_WIDTH-1:0]       ofm_addr;
    logic [DATA_WIDTH-1:0]       ofm_wdata;
    logic [DATA_WIDTH/8-1:0]     ofm_wstrb;

    modport master (
        output acc_valid, acc_data,
        input  acc_ready,
        input  ofm_we, ofm_addr, ofm_wdata, ofm_wstrb
    );

    modport slave (
        input  acc_valid, acc_data,
        output acc_ready,
        output ofm_we, ofm_addr, ofm_wdata, ofm_wstrb
    );

endinterface

// File: rtl/ofm_requant.sv
// One-lane combinational requantizer: round half up, arithmetic shift, saturate to int8.
// Optional ReLU clamp when OFM_RELU_EN is defined.
module ofm_requant
    import conv_pkg::*;
#(
    parameter int ACC_WIDTH = 16,
    parameter int SHIFT     = Q_W_DEFAULT
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic        [7:0]           q
);

    localparam logic signed [ACC_WIDTH:0] HALF   = (ACC_WIDTH+1)'(1) <<< (SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'(SAT_MAX);
    localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH+1)'(SAT_MIN);

    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] rounded;
    logic        [7:0]         sat;

    // One guard bit so the rounding add cannot wrap at the positive extreme.
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        sum     = $signed({acc[ACC_WIDTH-1], acc}) + HALF;
        rounded = sum >>> SHIFT;
        if (rounded > SAT_HI) begin
            sat = 8'h7F;
        end else if (rounded < SAT_LO) begin
            sat = 8'h80;
        end else begin
            sat = rounded[7:0];
        end
`ifdef OFM_RELU_EN
        q = sat[7] ? 8'h00 : sat;
`else
        q = sat;
`endif
    end

endmodule

// File: rtl/ofm_writeback.sv
// Requantize an accumulator stream to int8, pack LANES bytes per word and write words to
// the output BRAM from base_ofm_addr. Optional ReLU via the OFM_RELU_EN macro.
module ofm_writeback
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = LANES * 8,
    parameter int ACC_WIDTH  = 16,
    parameter int Q_IN       = Q_IN_DEFAULT,
    parameter int Q_W        = Q_W_DEFAULT,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_ofm_addr,
    input  logic [CNT_WIDTH-1:0]  num_pixels,
    ofm_writeback_if.slave        bus,
    output logic                  busy,
    output logic                  done
);

    localparam int LANE_CNT  = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(LANE_CNT);
    // Accumulator carries Q_IN+Q_W fraction bits; the output keeps Q_IN of them.
    localparam int SHIFT     = (Q_IN + Q_W) - Q_IN;

    st_t state, state_nx;

    logic [ADDR_WIDTH-1:0]     base_q;
    logic [ADDR_WIDTH-1:0]     word_idx;
    logic [CNT_WIDTH-1:0]      num_q;
    logic [CNT_WIDTH-1:0]      pix_cnt;
    logic                      accept;
    logic                      last_pix;
    logic [7:0]                q_byte;

    logic                      s1_valid;
    logic                      s1_last;
    logic [7:0]                s1_byte;
    logic [LANE_BITS-1:0]      s1_lane;

    logic [LANE_CNT-1:0][7:0]  pack_buf;
    logic [LANE_CNT-1:0][7:0]  word_nx;
    logic [LANE_CNT-1:0]       strb_nx;
    logic                      word_out;

    assign bus.acc_ready = (state == RUN);
    assign accept        = bus.acc_valid && bus.acc_ready;
    assign last_pix      = (pix_cnt == num_q - CNT_WIDTH'(1));

    ofm_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT)
    ) u_requant (
        .acc (bus.acc_data),
        .q   (q_byte)
    );

    // NOTE: reset is synchronous; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (num_pixels == '0) ? DONE : RUN;
            RUN:     if (accept && last_pix) state_nx = FLUSH;
            FLUSH:   if (s1_valid && s1_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A word leaves when its top lane fills or when the job's final pixel arrives;
    // strobes cover lanes 0..s1_lane, which is all ones for a full word.
    always_comb begin
        word_out = s1_valid && ((s1_lane == LANE_BITS'(LANE_CNT - 1)) || s1_last);
        word_nx  = pack_buf;
        strb_nx  = '0;
        for (int k = 0; k < LANE_CNT; k++) begin
            if (k == int'(s1_lane)) word_nx[k] = s1_byte;
            strb_nx[k] = (k <= int'(s1_lane));
        end
    end

    // NOTE: the pack buffer is reset and cleared per word because a partial word
    // must present zeros in its unused lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q        <= '0;
            num_q         <= '0;
            pix_cnt       <= '0;
            word_idx      <= '0;
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            s1_byte       <= '0;
            s1_lane       <= '0;
            pack_buf      <= '0;
            bus.ofm_we    <= 1'b0;
            bus.ofm_addr  <= '0;
            bus.ofm_wdata <= '0;
            bus.ofm_wstrb <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_last  <= accept && last_pix;
            if (accept) begin
                s1_byte <= q_byte;
                s1_lane <= pix_cnt[LANE_BITS-1:0];
                pix_cnt <= pix_cnt + CNT_WIDTH'(1);
            end

            if (state == IDLE && start) begin
                base_q   <= base_ofm_addr;
                num_q    <= num_pixels;
                pix_cnt  <= '0;
                word_idx <= '0;
                pack_buf <= '0;
            end

            bus.ofm_we <= word_out;
            if (word_out) begin
                pack_buf      <= '0;
                bus.ofm_addr  <= base_q + word_idx;
                bus.ofm_wdata <= word_nx;
                bus.ofm_wstrb <= strb_nx;
                word_idx      <= word_idx + ADDR_WIDTH'(1);
            end else if (s1_valid) begin
                pack_buf <= word_nx;
            end

            // busy covers the cycle after start acceptance through the done cycle.
            busy <= (state_nx != IDLE) || (state == DONE);
            done <= (state == DONE);
        end
    end

endmodule
